// File: rtl/raster_pkg.sv
// raster_pkg: shared coordinate/delta/error widths, cap_reg field positions and line FSM states.
package raster_pkg;
  localparam int CW = 10;
  localparam int DW = 11;
  localparam int EW = 13;
  localparam int CAP_W = 69;
  localparam int CAP_X_LSB = 59;
  localparam int CAP_Y_LSB = 49;
  localparam int CAP_DY_LSB = 18;
  localparam int CAP_DX_LSB = 7;
  localparam int CAP_PN = 0;
  typedef enum logic [1:0] {IDLE, SETUP, EMIT} state_t;
endpackage

// File: rtl/line_err_step.sv
// line_err_step: Bresenham step decision, next error term and next y for one point advance.
module line_err_step
  import raster_pkg::*;
(
  input  logic signed [EW-1:0] e,
  input  logic        [DW-1:0] ady,
  input  logic        [DW-1:0] dx,
  input  logic                 p_or_n,
  input  logic signed [CW-1:0] y,
  output logic signed [EW-1:0] e_nx,
  output logic signed [CW-1:0] y_nx
);
  logic signed [EW-1:0] two_ady, two_dx;
  logic step;
  assign two_ady = $signed({1'b0, ady, 1'b0});
  assign two_dx = $signed({1'b0, dx, 1'b0});
  // negative slopes step on a tie, positive slopes do not
  assign step = p_or_n ? !e[EW-1] : (!e[EW-1] && |e);
  assign e_nx = step ? e + two_ady - two_dx : e + two_ady;
  assign y_nx = step ? (p_or_n ? y - CW'(1) : y + CW'(1)) : y;
endmodule

// File: rtl/line_cap_ctrl.sv
// line_cap_ctrl: shallow-line Bresenham point generator with capture register.
// LINE_CAP_SWAP_EN: reverse lines are swapped and drawn from the lower-X end; otherwise rejected.
module line_cap_ctrl
  import raster_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    line_valid,
  output logic                    line_ready,
  input  logic        [CW-1:0]    x0_i,
  input  logic        [CW-1:0]    x1_i,
  input  logic signed [CW-1:0]    y0_i,
  input  logic signed [CW-1:0]    y1_i,
  output logic                    pt_valid,
  input  logic                    pt_ready,
  output logic        [CW-1:0]    pt_x,
  output logic signed [CW-1:0]    pt_y,
  output logic                    pt_last,
  output logic        [CAP_W-1:0] cap_reg,
  output logic                    err
);
  state_t state, state_n;
  logic        [CW-1:0] a0, a1, sx0, sx1, x, x_end;
  logic signed [CW-1:0] b0, b1, sy0, sy1, y, y_nx;
  logic        [DW-1:0] s_dx, s_ady, dx, ady;
  logic signed [DW-1:0] s_dy, dy;
  logic signed [EW-1:0] s_e, e, e_nx;
  logic p_or_n, rev, sw, reject, accept, hs;
  assign accept = line_valid & line_ready;
  assign hs = pt_valid & pt_ready;
  assign pt_last = pt_valid & (x == x_end);
  assign pt_x = x;
  assign pt_y = y;
  assign rev = a1 < a0;
  assign ady = dy[DW-1] ? DW'(-dy) : dy;
`ifdef LINE_CAP_SWAP_EN
  assign sw = rev;
  assign reject = s_ady > s_dx;
`else
  assign sw = 1'b0;
  assign reject = rev | (s_ady > s_dx);
`endif
  always_comb begin
    sx0 = sw ? a1 : a0;
    sx1 = sw ? a0 : a1;
    sy0 = sw ? b1 : b0;
    sy1 = sw ? b0 : b1;
    s_dx = {1'b0, sx1} - {1'b0, sx0};
    s_dy = {sy1[CW-1], sy1} - {sy0[CW-1], sy0};
    s_ady = s_dy[DW-1] ? DW'(-s_dy) : s_dy;
    s_e = $signed({1'b0, s_ady, 1'b0}) - $signed({2'b00, s_dx});
  end
  line_err_step u_step (
    .e(e),
    .ady(ady),
    .dx(dx),
    .p_or_n(p_or_n),
    .y(y),
    .e_nx(e_nx),
    .y_nx(y_nx)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE)  ? (accept ? SETUP : IDLE) :
              (state == SETUP) ? (reject ? IDLE : EMIT) :
              (hs && pt_last)  ? IDLE : EMIT;
  end
  // handshake outputs are registered from the next state so ready never bypasses
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      line_ready <= 1'b0;
      pt_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      line_ready <= state_n == IDLE;
      pt_valid <= state_n == EMIT;
      err <= (state == SETUP) && reject;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      a0 <= '0;
      a1 <= '0;
      b0 <= '0;
      b1 <= '0;
      x <= '0;
      x_end <= '0;
      y <= '0;
      e <= '0;
      dx <= '0;
      dy <= '0;
      p_or_n <= 1'b0;
    end else if (accept) begin
      a0 <= x0_i;
      a1 <= x1_i;
      b0 <= y0_i;
      b1 <= y1_i;
    end else if (state == SETUP) begin
      x <= sx0;
      x_end <= sx1;
      y <= sy0;
      e <= s_e;
      dx <= s_dx;
      dy <= s_dy;
      p_or_n <= s_dy[DW-1];
    end else if (hs && !pt_last) begin
      x <= x + CW'(1);
      y <= y_nx;
      e <= e_nx;
    end
  always_comb begin
    cap_reg = '0;
    cap_reg[CAP_X_LSB +: CW] = x;
    cap_reg[CAP_Y_LSB +: CW] = y;
    cap_reg[CAP_DY_LSB +: DW] = dy;
    cap_reg[CAP_DX_LSB +: DW] = dx;
    cap_reg[CAP_PN] = p_or_n;
  end
endmodule

// File: doc/line_cap_ctrl.md
LINE_CAP_CTRL -- requirements
Module: line_cap_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; the clock and reset ports are listed first below.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port line_valid, input, 1 bit: line request valid.
REQ-005 SHALL have port line_ready, output, 1 bit: block can accept a line.
REQ-006 SHALL have ports x0_i and x1_i, input, 10 bits each: unsigned endpoint X.
REQ-007 SHALL have ports y0_i and y1_i, input, 10 bits each: two's-complement endpoint Y.
REQ-008 SHALL have port pt_valid, output, 1 bit: generated point valid.
REQ-009 SHALL have port pt_ready, input, 1 bit: consumer accepts the point.
REQ-010 SHALL have ports pt_x (10 bits) and pt_y (10 bits, signed), output: current point.
REQ-011 SHALL have port pt_last, output, 1 bit: current point is the final point of the line.
REQ-012 SHALL have port cap_reg, output, 69 bits: [68:59] x, [58:49] y, [48:29] zero, [28:18] dy, [17:7] dx, [6:1] zero, [0] p_or_n (1 = negative slope).
REQ-013 SHALL have port err, output, 1 bit: one-cycle pulse when a line is rejected.

Function
REQ-014 SHALL implement the FSM states IDLE, SETUP and EMIT.
REQ-015 SHALL drive line_ready=1 only in IDLE.
REQ-016 SHALL latch the endpoints when line_valid and line_ready are both 1, and go to SETUP.
REQ-017 SHALL compute in SETUP (one cycle): dx=x1-x0, dy=y1-y0 (11-bit signed), p_or_n=(dy<0), initial error e=2|dy|-dx (13-bit signed), and load cap_reg.
REQ-018 SHALL, in SETUP, reject a steep line (|dy|>dx): pulse err for one cycle, then return to IDLE with no points emitted.
REQ-019 SHALL, in SETUP, handle a reverse line (x1<x0) as defined in the Configuration section.
REQ-020 SHALL go from SETUP to EMIT when the line is accepted; pt_valid first asserts two cycles after the accepting edge.
REQ-021 SHALL hold pt_valid=1 in EMIT and keep pt_x, pt_y, pt_last and cap_reg stable until pt_ready=1.
REQ-022 SHALL emit the start point (x0,y0) first, followed by dx further points, for a total of dx+1 points.
REQ-023 SHALL, on each point handshake that is not the last, set x=x+1 and step y as follows: if p_or_n=0, step when e>0 (a tie does not step); if p_or_n=1, step when e>=0 (a tie steps).
REQ-024 SHALL update the error on a y step as e+=2(|dy|-dx), and otherwise as e+=2|dy|.
REQ-025 SHALL make a y step +1 for positive slope and -1 for negative slope.
REQ-026 SHALL mirror the current x and y into cap_reg[68:49] for every point.
REQ-027 SHALL assert pt_last when x==x1.
REQ-028 SHALL return to IDLE on the pt_last handshake; line_ready rises on the next cycle and has no same-cycle bypass.
REQ-029 SHALL, for a zero-length line (x0==x1, y0==y1), emit exactly one point with pt_last=1.
REQ-030 SHALL, for a horizontal line (dy=0), keep y constant and set p_or_n=0.
REQ-031 SHALL wrap no arithmetic: dx spans at most 0..1023 and all intermediates are sized to avoid overflow.
REQ-032 SHALL ignore line_valid outside IDLE.

Reset
REQ-033 SHALL, while rst=0, asynchronously force: state=IDLE, line_ready=0, pt_valid=0, pt_last=0, err=0, cap_reg=0, pt_x=0, pt_y=0.
REQ-034 SHALL drive line_ready=1 in the first cycle after rst deasserts.
REQ-035 SHALL, when reset asserts mid-line, drop the line with no further points emitted after release.

Configuration
REQ-036 SHALL, with LINE_CAP_SWAP_EN defined, swap the endpoints of a reverse line in SETUP and emit it from the lower-X endpoint.
REQ-037 SHALL, without LINE_CAP_SWAP_EN, reject a reverse line exactly like a steep line (err pulse, no points).

Structure
REQ-038 SHALL take from shared package raster_pkg: coordinate widths (10), delta width (11), the cap_reg field bit positions, and the FSM state enum.
REQ-039 SHALL contain one sub-module, line_err_step: combinational next-error, step decision and next-y, instantiated once.

Verification
REQ-040 SHALL cover: (0,0)->(100,-50) with pt_ready always 1 -> 101 points; first point (0,0); second point (1,-1); last point (100,-50) with pt_last; cap_reg[0]=1.
REQ-041 SHALL cover: (0,0)->(100,50) -> second point (1,0); third point (2,1); last point (100,50); p_or_n=0.
REQ-042 SHALL cover: (5,5)->(5,5) -> exactly one point (5,5) with pt_last=1; line_ready=1 on the following cycle.
REQ-043 SHALL cover: (0,0)->(10,20) -> err pulse for one cycle; no pt_valid; back to IDLE.
REQ-044 SHALL cover: (100,-50)->(0,0) -> with LINE_CAP_SWAP_EN, points identical to REQ-040; without it, err pulse only.
REQ-045 SHALL cover: pt_ready toggled randomly on line (0,0)->(20,7) -> point sequence unchanged and outputs stable while stalled; a reset pulse after point 5 -> no further points and line_ready=1 after release.
